// File: rtl/usb_rst_seq_master.sv
// Avalon-MM master that cycles the USB chip reset through the PIO data register:
// write 0, hold, write 1, read back and verify, settle, then report done or error.
module usb_rst_seq_master #(
   parameter int ADDR_W         = 2,
   parameter int RST_ADDR       = 0,
   parameter int HOLD_CYCLES    = 50000,
   parameter int SETTLE_CYCLES  = 50000,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic              avm_read,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest
);

   typedef enum logic [2:0] {
      IDLE, WR_ASSERT, HOLD, WR_RELEASE, RD_CHECK, SETTLE, RELEASE_ABORT
   } state_t;

   localparam logic [ADDR_W-1:0] PIO_ADDR    = ADDR_W'(RST_ADDR);
   localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, to_cnt, to_cnt_nxt;
   logic              busy_nxt, done_nxt, error_nxt, write_nxt, read_nxt;
   logic [ADDR_W-1:0] address_nxt;
   logic [31:0]       writedata_nxt;
   logic              strobe, xfer_done, stalled, timed_out;
   logic              unused_readdata;

   // Only the reset bit of the PIO register is meaningful on readback.
   assign unused_readdata = ^avm_readdata[31:1];

   assign strobe    = avm_write | avm_read;
   assign xfer_done = strobe & ~avm_waitrequest;
   assign stalled   = strobe & avm_waitrequest;
   assign timed_out = stalled && (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         to_cnt        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         avm_write     <= 1'b0;
         avm_read      <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         to_cnt        <= to_cnt_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         error         <= error_nxt;
         avm_write     <= write_nxt;
         avm_read      <= read_nxt;
         avm_address   <= address_nxt;
         avm_writedata <= writedata_nxt;
      end
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      to_cnt_nxt    = stalled ? to_cnt + CNT_ONE : to_cnt;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      error_nxt     = error;
      write_nxt     = avm_write;
      read_nxt      = avm_read;
      address_nxt   = avm_address;
      writedata_nxt = avm_writedata;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt     = WR_ASSERT;
               busy_nxt      = 1'b1;
               error_nxt     = 1'b0;
               write_nxt     = 1'b1;
               address_nxt   = PIO_ADDR;
               writedata_nxt = 32'h0;
               to_cnt_nxt    = '0;
            end
         end
         WR_ASSERT: begin
            if (xfer_done) begin
               write_nxt = 1'b0;
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nxt     = WR_RELEASE;
               write_nxt     = 1'b1;
               address_nxt   = PIO_ADDR;
               writedata_nxt = 32'h1;
               to_cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         WR_RELEASE: begin
            if (xfer_done) begin
               write_nxt = 1'b0;
               state_nxt = RD_CHECK;
            end
         end
         // Entered with the bus idle; the read goes out one cycle later.
         RD_CHECK: begin
            if (!avm_read) begin
               read_nxt    = 1'b1;
               address_nxt = PIO_ADDR;
               to_cnt_nxt  = '0;
            end else if (xfer_done) begin
               read_nxt = 1'b0;
               if (avm_readdata[0]) begin
                  state_nxt = SETTLE;
                  cnt_nxt   = SETTLE_LOAD;
               end else begin
                  error_nxt = 1'b1;
                  state_nxt = RELEASE_ABORT;
               end
            end
         end
         SETTLE: begin
            if (cnt == '0) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         RELEASE_ABORT: begin
            if (!avm_write) begin
               write_nxt     = 1'b1;
               address_nxt   = PIO_ADDR;
               writedata_nxt = 32'h1;
               to_cnt_nxt    = '0;
            end else if (xfer_done) begin
               write_nxt = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A hung bus gets abandoned outright; no release write is attempted.
      if (timed_out) begin
         write_nxt = 1'b0;
         read_nxt  = 1'b0;
         error_nxt = 1'b1;
         busy_nxt  = 1'b0;
         state_nxt = IDLE;
      end
   end

endmodule
